// File: rtl/msgpass_rqst_writer.sv
// msgpass_rqst_writer: write-side sequencer for the message-pass buffer.
// Packs one share-group request beat per page, writes pages to buffer
// port A in circular order, and tracks occupancy against reader consumes.

// Packs one lane: enable flag on top, address below (zeroed when disabled).
module msgpass_lane_pack #(
   parameter int ADDR_W = 3
) (
   input  logic              laneEn,
   input  logic [ADDR_W-1:0] laneAddr,
   output logic [ADDR_W:0]   laneWord
);
   assign laneWord = laneEn ? {1'b1, laneAddr} : '0;
endmodule

module msgpass_rqst_writer #(
   parameter  int SHARE_GROUP_SIZE   = 5,
   parameter  int RQST_ADDR_BITWIDTH = 3,
   parameter  int BUFF_DEPTH         = 8,
   localparam int LANE_WIDTH         = RQST_ADDR_BITWIDTH + 1,
   localparam int BUFF_ADDR_WIDTH    = $clog2(BUFF_DEPTH)
) (
   input  logic                                       sys_clk,
   input  logic                                       rst,
   input  logic                                       rqst_valid_i,
   output logic                                       rqst_ready_o,
   input  logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] rqst_addr_i,
   input  logic [SHARE_GROUP_SIZE-1:0]                rqst_lane_en_i,
   input  logic                                       rqst_last_i,
   input  logic                                       page_consumed_i,
   output logic [BUFF_ADDR_WIDTH-1:0]                 waddr_o,
   output logic [SHARE_GROUP_SIZE*LANE_WIDTH-1:0]     wdata_o,
   output logic                                       wen_o,
   output logic [BUFF_ADDR_WIDTH:0]                   occupancy_o,
   output logic                                       full_o,
   output logic                                       empty_o,
   output logic                                       layer_done_o,
   output logic                                       underflow_o
);

   localparam logic [BUFF_ADDR_WIDTH:0] FULL_CNT = (BUFF_ADDR_WIDTH+1)'(BUFF_DEPTH);

   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

   typedef struct packed {
      logic                                               last;
      logic [SHARE_GROUP_SIZE-1:0]                        laneEn;
      logic [SHARE_GROUP_SIZE-1:0][RQST_ADDR_BITWIDTH-1:0] laneAddr;
   } rqst_t;

   state_t                                     state;
   rqst_t                                      rqst;
   logic [SHARE_GROUP_SIZE-1:0][LANE_WIDTH-1:0] laneWords;
   logic [SHARE_GROUP_SIZE-1:0][LANE_WIDTH-1:0] wdataReg;
   logic [BUFF_ADDR_WIDTH-1:0]                 wrPtr;
   logic [BUFF_ADDR_WIDTH-1:0]                 waddrReg;
   logic [BUFF_ADDR_WIDTH:0]                   occCnt;
   logic                                       wenN;
   logic                                       layerDone;
   logic                                       underflow;
   logic                                       full;
   logic                                       empty;
   logic                                       ready;
   logic                                       accept;

   assign rqst.last     = rqst_last_i;
   assign rqst.laneEn   = rqst_lane_en_i;
   assign rqst.laneAddr = rqst_addr_i;

   // Flags come straight off the registered count, so ready never depends on valid.
   assign full   = (occCnt == FULL_CNT);
   assign empty  = (occCnt == '0);
   assign ready  = (state != DRAIN) && !full;
   assign accept = rqst_valid_i && ready;

   for (genvar i = 0; i < SHARE_GROUP_SIZE; i++) begin : gLane
      msgpass_lane_pack #(.ADDR_W(RQST_ADDR_BITWIDTH)) uPack (
         .laneEn   (rqst.laneEn[i]),
         .laneAddr (rqst.laneAddr[i]),
         .laneWord (laneWords[i])
      );
   end

   // Write port: one-cycle write per accepted beat, address is the pre-increment pointer.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         wenN     <= 1'b1;
         waddrReg <= '0;
         wdataReg <= '0;
      end else begin
         wenN <= !accept;
         if (accept) begin
            waddrReg <= wrPtr;
            wdataReg <= laneWords;
         end
      end
   end

   // Pointer and occupancy; an accept and a consume in the same cycle cancel out.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         wrPtr     <= '0;
         occCnt    <= '0;
         underflow <= 1'b0;
      end else begin
         if (accept)
            wrPtr <= wrPtr + 1'b1;
         if (accept && !page_consumed_i)
            occCnt <= occCnt + 1'b1;
         else if (!accept && page_consumed_i && !empty)
            occCnt <= occCnt - 1'b1;
         if (!accept && page_consumed_i && empty)
            underflow <= 1'b1;
      end
   end

   // Layer FSM: a last beat closes the layer; drain until empty, then pulse done.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state     <= IDLE;
         layerDone <= 1'b0;
      end else begin
         layerDone <= 1'b0;
         case (state)
            IDLE:    if (accept) state <= rqst.last ? DRAIN : FILL;
            FILL:    if (accept && rqst.last) state <= DRAIN;
            DRAIN:   if (empty) begin
                        layerDone <= 1'b1;
                        state     <= IDLE;
                     end
            default: state <= IDLE;
         endcase
      end
   end

   assign rqst_ready_o = ready;
   assign waddr_o      = waddrReg;
   assign wdata_o      = wdataReg;
   assign wen_o        = wenN;
   assign occupancy_o  = occCnt;
   assign full_o       = full;
   assign empty_o      = empty;
   assign layer_done_o = layerDone;
   assign underflow_o  = underflow;

endmodule

// File: tb/tb_msgpass_rqst_writer.sv
// tb_msgpass_rqst_writer: scoreboard bench for the message-pass write sequencer.
module tb_msgpass_rqst_writer;

   localparam int N  = 5;
   localparam int A  = 3;
   localparam int L  = A + 1;
   localparam int AW = 3;

   logic              sys_clk = 1'b0;
   logic              rst = 1'b1;
   logic              rqst_valid_i = 1'b0;
   logic              rqst_ready_o;
   logic [N*A-1:0]    rqst_addr_i = '0;
   logic [N-1:0]      rqst_lane_en_i = '0;
   logic              rqst_last_i = 1'b0;
   logic              page_consumed_i = 1'b0;
   logic [AW-1:0]     waddr_o;
   logic [N*L-1:0]    wdata_o;
   logic              wen_o;
   logic [AW:0]       occupancy_o;
   logic              full_o;
   logic              empty_o;
   logic              layer_done_o;
   logic              underflow_o;

   typedef struct {
      logic [AW-1:0]  addr;
      logic [N*L-1:0] data;
   } exp_t;

   exp_t          sb[$];
   logic [AW-1:0] expPtr = '0;
   int            checks = 0;
   int            failures = 0;
   int            doneCnt = 0;

   msgpass_rqst_writer #(.SHARE_GROUP_SIZE(N), .RQST_ADDR_BITWIDTH(A), .BUFF_DEPTH(8)) dut (
      .sys_clk         (sys_clk),
      .rst             (rst),
      .rqst_valid_i    (rqst_valid_i),
      .rqst_ready_o    (rqst_ready_o),
      .rqst_addr_i     (rqst_addr_i),
      .rqst_lane_en_i  (rqst_lane_en_i),
      .rqst_last_i     (rqst_last_i),
      .page_consumed_i (page_consumed_i),
      .waddr_o         (waddr_o),
      .wdata_o         (wdata_o),
      .wen_o           (wen_o),
      .occupancy_o     (occupancy_o),
      .full_o          (full_o),
      .empty_o         (empty_o),
      .layer_done_o    (layer_done_o),
      .underflow_o     (underflow_o)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [N*L-1:0] packPage(input logic [N*A-1:0] a, input logic [N-1:0] en);
      logic [N*L-1:0] p;
      p = '0;
      for (int i = 0; i < N; i++)
         if (en[i]) p[i*L +: L] = {1'b1, a[i*A +: A]};
      return p;
   endfunction

   // Write monitor: every buffer write must match the oldest pending expectation.
   always @(negedge sys_clk) begin
      if (!rst) begin
         if (layer_done_o) doneCnt++;
         if (!wen_o) begin
            if (sb.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("waddr", 32'(waddr_o), 32'(e.addr));
               chk("wdata", 32'(wdata_o), 32'(e.data));
            end
         end
      end
   end

   task automatic sendBeat(input logic [N*A-1:0] a, input logic [N-1:0] en, input logic last);
      bit accepted;
      accepted = 0;
      rqst_valid_i = 1'b1;
      rqst_addr_i = a;
      rqst_lane_en_i = en;
      rqst_last_i = last;
      for (int c = 0; c < 20 && !accepted; c++) begin
         @(negedge sys_clk);
         if (rqst_ready_o) begin
            sb.push_back('{expPtr, packPage(a, en)});
            expPtr++;
            accepted = 1;
         end
         @(posedge sys_clk); #1;
      end
      rqst_valid_i = 1'b0;
      rqst_last_i = 1'b0;
      if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic consume();
      page_consumed_i = 1'b1;
      @(posedge sys_clk); #1;
      page_consumed_i = 1'b0;
   endtask

   task automatic step();
      @(posedge sys_clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW:0] occExp;
      // Reset state
      repeat (3) @(posedge sys_clk);
      #1 rst = 1'b0;
      @(negedge sys_clk);
      chk("rst_wen", 32'(wen_o), 32'd1);
      chk("rst_waddr", 32'(waddr_o), 32'd0);
      chk("rst_wdata", 32'(wdata_o), 32'd0);
      chk("rst_occ", 32'(occupancy_o), 32'd0);
      chk("rst_empty", 32'(empty_o), 32'd1);
      chk("rst_full", 32'(full_o), 32'd0);
      chk("rst_ready", 32'(rqst_ready_o), 32'd1);
      chk("rst_done", 32'(layer_done_o), 32'd0);
      chk("rst_uflow", 32'(underflow_o), 32'd0);
      step();

      // Three-beat layer, last on beat 3
      sendBeat(15'h7FFF, 5'b00001, 1'b0);
      @(negedge sys_clk);
      chk("beat1_const", 32'(wdata_o), 32'h0000F);
      step();
      sendBeat(15'($urandom), 5'b00110, 1'b0);
      sendBeat(15'($urandom), 5'b10010, 1'b1);
      chk("l3_occ", 32'(occupancy_o), 32'd3);
      chk("l3_ready", 32'(rqst_ready_o), 32'd0);
      for (int k = 2; k >= 0; k--) begin
         consume();
         chk("l3_drain_occ", 32'(occupancy_o), 32'(k));
      end
      chk("l3_done_early", 32'(layer_done_o), 32'd0);
      chk("l3_ready_drain", 32'(rqst_ready_o), 32'd0);
      step();
      chk("l3_done", 32'(layer_done_o), 32'd1);
      chk("l3_ready_back", 32'(rqst_ready_o), 32'd1);
      step();
      chk("l3_done_once", 32'(layer_done_o), 32'd0);

      // Reset mid-FILL with occupancy 3
      for (int k = 0; k < 3; k++) sendBeat(15'($urandom), 5'($urandom), 1'b0);
      chk("mid_occ", 32'(occupancy_o), 32'd3);
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      sb.delete();
      expPtr = '0;
      chk("mrst_wen", 32'(wen_o), 32'd1);
      chk("mrst_occ", 32'(occupancy_o), 32'd0);
      chk("mrst_empty", 32'(empty_o), 32'd1);
      chk("mrst_ready", 32'(rqst_ready_o), 32'd1);
      sendBeat(15'($urandom), 5'b11111, 1'b0);
      @(negedge sys_clk);
      chk("mrst_waddr0", 32'(waddr_o), 32'd0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      expPtr = '0;

      // Fill to full, one consume, wrap
      for (int k = 0; k < 8; k++) sendBeat(15'($urandom), 5'($urandom), 1'b0);
      chk("full_flag", 32'(full_o), 32'd1);
      chk("full_ready", 32'(rqst_ready_o), 32'd0);
      chk("full_occ", 32'(occupancy_o), 32'd8);
      consume();
      chk("unfull_occ", 32'(occupancy_o), 32'd7);
      chk("unfull_ready", 32'(rqst_ready_o), 32'd1);
      sendBeat(15'($urandom), 5'($urandom), 1'b0);
      @(negedge sys_clk);
      chk("wrap_addr", 32'(waddr_o), 32'd0);
      step();

      // Simultaneous accept and consume at occupancy 4
      repeat (4) consume();
      chk("sim_pre_occ", 32'(occupancy_o), 32'd4);
      page_consumed_i = 1'b1;
      sendBeat(15'($urandom), 5'($urandom), 1'b0);
      page_consumed_i = 1'b0;
      chk("sim_occ", 32'(occupancy_o), 32'd4);
      @(negedge sys_clk);
      chk("sim_waddr", 32'(waddr_o), 32'd1);
      step();

      // Close the layer and drain
      sendBeat(15'($urandom), 5'($urandom), 1'b1);
      occExp = occupancy_o;
      chk("close_occ", 32'(occExp), 32'd5);
      for (int k = 0; k < 5; k++) consume();
      step();
      chk("close_done", 32'(layer_done_o), 32'd1);
      step();
      chk("close_empty", 32'(empty_o), 32'd1);
      chk("close_ready", 32'(rqst_ready_o), 32'd1);

      // Underflow: sticky until reset
      consume();
      chk("uf_occ", 32'(occupancy_o), 32'd0);
      chk("uf_flag", 32'(underflow_o), 32'd1);
      repeat (3) step();
      chk("uf_sticky", 32'(underflow_o), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("uf_cleared", 32'(underflow_o), 32'd0);
      step();

      chk("done_pulses", 32'(doneCnt), 32'd2);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
